// File: rtl/i2c_access_arbiter.sv
// ============================================================================
// i2c_access_arbiter
// ----------------------------------------------------------------------------
// Shares the single I2C command path between N_REQ requesters. The path is the
// write FIFO, command parser, DAQ/TRG laser-driver interfaces and readback
// FIFO. Requesters are granted one at a time in round-robin order. The FIFOs
// are flushed before every grant. The granted requester's FIFO strobes are
// muxed onto the shared path. The arbiter drives I2C_START, holds it until the
// parser reports completion, and aborts the sequence on timeout.
//
// Ports:
//   CLK40              system clock
//   rst_fifo           asynchronous active-high reset
//   REQ[N]             level request per requester
//   REQ_WDATA[8N]      write-FIFO byte per requester (i at [8i+7:8i])
//   REQ_WE[N]          write strobe per requester
//   REQ_GO[N]          pulse: command loaded, start the sequence
//   REQ_RDENA[N]       readback-FIFO read enable per requester
//   REQ_REL[N]         pulse: release the grant
//   I2C_CLR_START      sequence-complete pulse from the parser
//   GNT[N]             one-hot grant
//   DONE[N]            one-cycle pulse to the granted requester at sequence end
//   ERR                sticky per grant (timeout/overflow), valid with DONE
//   I2C_WRT_FIFO_DATA  muxed write byte
//   I2C_WE             muxed write strobe
//   I2C_RDENA          muxed readback read enable
//   I2C_RESET          FIFO/parser flush
//   I2C_START          start to the parser
//   BUSY               arbiter not idle
//   ARB_STATE          state code for status/ChipScope
// ============================================================================
module i2c_access_arbiter #(
    parameter int          N_REQ       = 2,
    parameter logic [19:0] TIMEOUT_CYC = 20'd400000,
    parameter int          MAX_BYTES   = 31
) (
    input  logic                 CLK40,
    input  logic                 rst_fifo,
    input  logic [N_REQ-1:0]     REQ,
    input  logic [8*N_REQ-1:0]   REQ_WDATA,
    input  logic [N_REQ-1:0]     REQ_WE,
    input  logic [N_REQ-1:0]     REQ_GO,
    input  logic [N_REQ-1:0]     REQ_RDENA,
    input  logic [N_REQ-1:0]     REQ_REL,
    input  logic                 I2C_CLR_START,
    output logic [N_REQ-1:0]     GNT,
    output logic [N_REQ-1:0]     DONE,
    output logic                 ERR,
    output logic [7:0]           I2C_WRT_FIFO_DATA,
    output logic                 I2C_WE,
    output logic                 I2C_RDENA,
    output logic                 I2C_RESET,
    output logic                 I2C_START,
    output logic                 BUSY,
    output logic [2:0]           ARB_STATE
);

    localparam int BW = $clog2(MAX_BYTES + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FLUSH = 3'd1,
        LOAD  = 3'd2,
        RUN   = 3'd3,
        RBK   = 3'd4,
        ABORT = 3'd5
    } state_t;

    state_t           state, state_n;
    logic [N_REQ-1:0] gnt, gnt_n;
    logic [N_REQ-1:0] done_r, done_n;
    logic [1:0]       gidx, gidx_n;
    logic [1:0]       ptr, ptr_n;
    logic [BW-1:0]    byte_cnt, byte_n, byte_upd;
    logic [19:0]      to_cnt, to_n;
    logic             err, err_n, err_upd;
    logic             phase, phase_n;
    logic             start_r, start_n;

    logic [1:0]       sel;
    logic             found;
    logic             req_g, we_g, go_g, rd_g, rel_g;
    logic [7:0]       wdata_g;
    logic             load_live, wr_ok, wr_ovf;

    // Round-robin pick: first REQ at or after the pointer, else first overall.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (!found && REQ[k] && (k >= 32'(ptr))) begin
                found = 1'b1;
                sel   = 2'(k);
            end
        end
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (!found && REQ[k]) begin
                found = 1'b1;
                sel   = 2'(k);
            end
        end
    end

    // Strobes of the granted requester.
    always_comb begin
        req_g   = 1'b0;
        we_g    = 1'b0;
        go_g    = 1'b0;
        rd_g    = 1'b0;
        rel_g   = 1'b0;
        wdata_g = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (gidx == 2'(k)) begin
                req_g   = REQ[k];
                we_g    = REQ_WE[k];
                go_g    = REQ_GO[k];
                rd_g    = REQ_RDENA[k];
                rel_g   = REQ_REL[k];
                wdata_g = REQ_WDATA[8*k +: 8];
            end
        end
    end

    // A release (explicit or REQ dropped) in LOAD wins over a same-cycle write.
    assign load_live = (state == LOAD) && req_g && !rel_g;
    assign wr_ovf    = load_live && we_g && (byte_cnt == BW'(MAX_BYTES));
    assign wr_ok     = load_live && we_g && (byte_cnt != BW'(MAX_BYTES));
    assign byte_upd  = wr_ok ? byte_cnt + BW'(1) : byte_cnt;
    assign err_upd   = err | wr_ovf;

    always_ff @(posedge CLK40 or posedge rst_fifo) begin
        if (rst_fifo) begin
            state    <= IDLE;
            gnt      <= '0;
            done_r   <= '0;
            gidx     <= '0;
            ptr      <= '0;
            byte_cnt <= '0;
            to_cnt   <= '0;
            err      <= 1'b0;
            phase    <= 1'b0;
            start_r  <= 1'b0;
        end else begin
            state    <= state_n;
            gnt      <= gnt_n;
            done_r   <= done_n;
            gidx     <= gidx_n;
            ptr      <= ptr_n;
            byte_cnt <= byte_n;
            to_cnt   <= to_n;
            err      <= err_n;
            phase    <= phase_n;
            start_r  <= start_n;
        end
    end

    always_comb begin
        state_n = state;
        gnt_n   = gnt;
        done_n  = '0;
        gidx_n  = gidx;
        ptr_n   = ptr;
        byte_n  = byte_cnt;
        to_n    = to_cnt;
        err_n   = err;
        phase_n = phase;
        start_n = start_r;

        case (state)
            IDLE: begin
                if (found) begin
                    for (int unsigned k = 0; k < N_REQ; k++) begin
                        gnt_n[k] = (2'(k) == sel);
                    end
                    gidx_n  = sel;
                    ptr_n   = (sel == 2'(N_REQ - 1)) ? 2'd0 : sel + 2'd1;
                    err_n   = 1'b0;
                    byte_n  = '0;
                    to_n    = '0;
                    phase_n = 1'b0;
                    state_n = FLUSH;
                end
            end

            FLUSH: begin
                phase_n = ~phase;
                if (phase) begin
                    state_n = LOAD;
                end
            end

            LOAD: begin
                if (!req_g || rel_g) begin
                    gnt_n   = '0;
                    byte_n  = '0;
                    to_n    = '0;
                    state_n = IDLE;
                end else begin
                    // GO is judged against the count/error including a same-cycle write.
                    byte_n = byte_upd;
                    err_n  = err_upd;
                    if (go_g) begin
                        phase_n = 1'b0;
                        if (byte_upd == '0) begin
                            err_n   = 1'b1;
                            state_n = ABORT;
                        end else if (err_upd) begin
                            state_n = ABORT;
                        end else begin
                            start_n = 1'b1;
                            to_n    = '0;
                            state_n = RUN;
                        end
                    end
                end
            end

            RUN: begin
                if (I2C_CLR_START) begin
                    start_n = 1'b0;
                    done_n  = gnt;
                    state_n = RBK;
                end else if (to_cnt == TIMEOUT_CYC - 20'd1) begin
                    start_n = 1'b0;
                    err_n   = 1'b1;
                    phase_n = 1'b0;
                    state_n = ABORT;
                end else begin
                    to_n = to_cnt + 20'd1;
                end
            end

            RBK: begin
                if (rel_g || !req_g) begin
                    gnt_n   = '0;
                    byte_n  = '0;
                    to_n    = '0;
                    state_n = IDLE;
                end
            end

            ABORT: begin
                phase_n = ~phase;
                if (phase) begin
                    done_n  = gnt;
                    gnt_n   = '0;
                    byte_n  = '0;
                    to_n    = '0;
                    state_n = IDLE;
                end
            end

            default: begin
                gnt_n   = '0;
                start_n = 1'b0;
                state_n = IDLE;
            end
        endcase
    end

    assign GNT               = gnt;
    assign DONE              = done_r;
    assign ERR               = err;
    assign I2C_WE            = wr_ok;
    assign I2C_WRT_FIFO_DATA = (state == LOAD) ? wdata_g : '0;
    assign I2C_RDENA         = (state == RBK) && rd_g;
    assign I2C_RESET         = (state == FLUSH) || (state == ABORT);
    assign I2C_START         = start_r;
    assign BUSY              = (state != IDLE);
    assign ARB_STATE         = state;

endmodule

// File: tb/tb_i2c_access_arbiter.sv
// ============================================================================
// tb_i2c_access_arbiter
// ----------------------------------------------------------------------------
// Directed bench for i2c_access_arbiter (N_REQ=2, TIMEOUT_CYC=100). Stimulus
// tasks push the expected events into a queue. A negedge monitor turns DUT
// activity into the same kinds of events and compares them in order: grant
// rise (with the idle gap before it), I2C_RESET run length, accepted write
// byte, readback strobe, I2C_START run length and DONE/ERR.
// ============================================================================
module tb_i2c_access_arbiter;

    localparam int EV_GRANT = 0;
    localparam int EV_RST   = 1;
    localparam int EV_WR    = 2;
    localparam int EV_RD    = 3;
    localparam int EV_START = 4;
    localparam int EV_DONE  = 5;

    typedef struct {
        int kind;
        int value;
        int gap;    // -1: idle gap not checked
    } ev_t;

    logic        CLK40    = 1'b0;
    logic        rst_fifo = 1'b1;
    logic [1:0]  req      = '0;
    logic [15:0] wdata    = '0;
    logic [1:0]  we       = '0;
    logic [1:0]  go       = '0;
    logic [1:0]  rdena    = '0;
    logic [1:0]  rel      = '0;
    logic        clr      = 1'b0;

    logic [1:0]  GNT;
    logic [1:0]  DONE;
    logic        ERR;
    logic [7:0]  I2C_WRT_FIFO_DATA;
    logic        I2C_WE;
    logic        I2C_RDENA;
    logic        I2C_RESET;
    logic        I2C_START;
    logic        BUSY;
    logic [2:0]  ARB_STATE;

    i2c_access_arbiter #(
        .N_REQ       (2),
        .TIMEOUT_CYC (20'd100),
        .MAX_BYTES   (31)
    ) dut (
        .CLK40             (CLK40),
        .rst_fifo          (rst_fifo),
        .REQ               (req),
        .REQ_WDATA         (wdata),
        .REQ_WE            (we),
        .REQ_GO            (go),
        .REQ_RDENA         (rdena),
        .REQ_REL           (rel),
        .I2C_CLR_START     (clr),
        .GNT               (GNT),
        .DONE              (DONE),
        .ERR               (ERR),
        .I2C_WRT_FIFO_DATA (I2C_WRT_FIFO_DATA),
        .I2C_WE            (I2C_WE),
        .I2C_RDENA         (I2C_RDENA),
        .I2C_RESET         (I2C_RESET),
        .I2C_START         (I2C_START),
        .BUSY              (BUSY),
        .ARB_STATE         (ARB_STATE)
    );

    always #5 CLK40 = ~CLK40;

    int  vectors     = 0;
    int  miscompares = 0;
    ev_t exp_q[$];

    function automatic string kname(int k);
        case (k)
            EV_GRANT: return "grant";
            EV_RST:   return "i2c_reset_len";
            EV_WR:    return "write_byte";
            EV_RD:    return "rdena";
            EV_START: return "i2c_start_len";
            EV_DONE:  return "done_err";
            default:  return "unknown";
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic observe(input int k, input int v, input int g);
        ev_t e;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL %s: unexpected event, got value %0d", kname(k), v);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.value != v || (e.gap >= 0 && e.gap != g)) begin
                miscompares++;
                $display("FAIL %s: got %s value %0d gap %0d, required %s value %0d gap %0d",
                         kname(e.kind), kname(k), v, g, kname(e.kind), e.value, e.gap);
            end
        end
    endtask

    // Monitor
    logic [1:0] prev_gnt  = '0;
    int         zero_run  = 0;
    int         rst_run   = 0;
    int         start_run = 0;

    always @(negedge CLK40) begin
        if (rst_fifo) begin
            prev_gnt  = '0;
            zero_run  = 0;
            rst_run   = 0;
            start_run = 0;
        end else begin
            if (GNT != 2'b00 && prev_gnt == 2'b00) observe(EV_GRANT, int'(GNT), zero_run);
            zero_run = (GNT == 2'b00) ? zero_run + 1 : 0;
            prev_gnt = GNT;
            if (!I2C_RESET && rst_run != 0) observe(EV_RST, rst_run, -1);
            rst_run = I2C_RESET ? rst_run + 1 : 0;
            if (I2C_WE) observe(EV_WR, int'(I2C_WRT_FIFO_DATA), -1);
            if (I2C_RDENA) observe(EV_RD, 0, -1);
            if (!I2C_START && start_run != 0) observe(EV_START, start_run, -1);
            start_run = I2C_START ? start_run + 1 : 0;
            if (DONE != 2'b00) observe(EV_DONE, int'(DONE) * 2 + int'(ERR), -1);
        end
    end

    // Stimulus helpers
    task automatic tick;
        @(posedge CLK40);
        #1;
    endtask

    task automatic expect_ev(input int k, input int v, input int g);
        ev_t e;
        e.kind  = k;
        e.value = v;
        e.gap   = g;
        exp_q.push_back(e);
    endtask

    // Raise REQ (if not already), then step through IDLE -> FLUSH x2 -> LOAD.
    task automatic grant(input logic r, input int gap);
        expect_ev(EV_GRANT, r ? 2 : 1, gap);
        expect_ev(EV_RST, 2, -1);
        req[r] = 1'b1;
        tick;
        chk("state_flush", int'(ARB_STATE), 1);
        chk("gnt_after_1", int'(GNT), r ? 2 : 1);
        repeat (2) tick;
        chk("state_load", int'(ARB_STATE), 2);
    endtask

    task automatic write_byte(input logic r, input logic [7:0] b, input bit accepted);
        if (accepted) expect_ev(EV_WR, int'(b), -1);
        we[r] = 1'b1;
        if (r) wdata[15:8] = b;
        else   wdata[7:0]  = b;
        tick;
        we[r] = 1'b0;
    endtask

    // GO, then the parser answers CLR_START on the len-th cycle of I2C_START.
    task automatic run_ok(input logic r, input int len);
        expect_ev(EV_START, len, -1);
        expect_ev(EV_DONE, (r ? 2 : 1) * 2, -1);
        go[r] = 1'b1;
        tick;
        go[r] = 1'b0;
        repeat (len - 1) tick;
        clr = 1'b1;
        tick;
        clr = 1'b0;
    endtask

    task automatic release_grant(input logic r);
        rel[r] = 1'b1;
        tick;
        rel[r] = 1'b0;
    endtask

    initial begin
        ev_t e;

        // Reset values
        repeat (3) tick;
        chk("rst_gnt", int'(GNT), 0);
        chk("rst_busy", int'(BUSY), 0);
        chk("rst_state", int'(ARB_STATE), 0);
        chk("rst_start", int'(I2C_START), 0);
        chk("rst_i2c_reset", int'(I2C_RESET), 0);
        chk("rst_done", int'(DONE), 0);
        chk("rst_err", int'(ERR), 0);
        rst_fifo = 1'b0;
        tick;

        // Single requester: 3 bytes, 50-cycle sequence; requester 1 WE ignored
        grant(1'b0, -1);
        we[1] = 1'b1;
        wdata[15:8] = 8'hAA;
        write_byte(1'b0, 8'h04, 1'b1);
        write_byte(1'b0, 8'h76, 1'b1);
        write_byte(1'b0, 8'h00, 1'b1);
        we[1] = 1'b0;
        clr = 1'b1;              // CLR_START outside RUN: no effect
        tick;
        clr = 1'b0;
        chk("clr_in_load_start", int'(I2C_START), 0);
        chk("clr_in_load_state", int'(ARB_STATE), 2);
        run_ok(1'b0, 50);
        chk("state_rbk", int'(ARB_STATE), 4);
        release_grant(1'b0);
        req[0] = 1'b0;
        tick;

        // Overflow: 32nd byte suppressed, GO aborts, START never raised
        grant(1'b1, -1);
        for (int i = 0; i < 32; i++) begin
            write_byte(1'b1, 8'(8'h10 + i), i < 31);
        end
        chk("ovf_err", int'(ERR), 1);
        expect_ev(EV_RST, 2, -1);
        expect_ev(EV_DONE, 2 * 2 + 1, -1);
        go[1] = 1'b1;
        tick;
        go[1] = 1'b0;
        req[1] = 1'b0;
        chk("ovf_abort_state", int'(ARB_STATE), 5);
        repeat (3) tick;

        // Both requesters held: 01,10,01,10 with one idle cycle between grants
        req = 2'b11;
        grant(1'b0, -1);
        write_byte(1'b0, 8'h21, 1'b1);
        run_ok(1'b0, 5);
        release_grant(1'b0);
        grant(1'b1, 1);
        write_byte(1'b1, 8'h22, 1'b1);
        run_ok(1'b1, 7);
        release_grant(1'b1);
        grant(1'b0, 1);
        write_byte(1'b0, 8'h23, 1'b1);
        run_ok(1'b0, 3);
        tick;
        // Readback: 4 pulses from requester 0, requester 1 toggling
        for (int i = 0; i < 4; i++) expect_ev(EV_RD, 0, -1);
        for (int i = 0; i < 8; i++) begin
            rdena[0] = (i % 2 == 0);
            rdena[1] = ~rdena[1];
            tick;
        end
        rdena = '0;
        release_grant(1'b0);
        grant(1'b1, 1);
        write_byte(1'b1, 8'h24, 1'b1);
        run_ok(1'b1, 4);
        release_grant(1'b1);
        req = 2'b00;
        tick;

        // Timeout, with REQ dropped during RUN (ignored until the end)
        grant(1'b0, -1);
        write_byte(1'b0, 8'h5A, 1'b1);
        expect_ev(EV_START, 100, -1);
        expect_ev(EV_RST, 2, -1);
        expect_ev(EV_DONE, 1 * 2 + 1, -1);
        go[0] = 1'b1;
        tick;
        go[0] = 1'b0;
        req[0] = 1'b0;
        repeat (104) tick;
        chk("timeout_busy", int'(BUSY), 0);
        chk("timeout_err", int'(ERR), 1);

        // GO with no bytes loaded aborts with ERR
        grant(1'b1, -1);
        expect_ev(EV_RST, 2, -1);
        expect_ev(EV_DONE, 2 * 2 + 1, -1);
        go[1] = 1'b1;
        tick;
        go[1] = 1'b0;
        req[1] = 1'b0;
        repeat (3) tick;
        chk("zero_go_err", int'(ERR), 1);

        // Reset in the middle of RUN
        grant(1'b0, -1);
        write_byte(1'b0, 8'h11, 1'b1);
        go[0] = 1'b1;
        tick;
        go[0] = 1'b0;
        repeat (10) tick;
        chk("midrun_start", int'(I2C_START), 1);
        #2 rst_fifo = 1'b1;
        #1;
        chk("async_start", int'(I2C_START), 0);
        chk("async_gnt", int'(GNT), 0);
        chk("async_busy", int'(BUSY), 0);
        req = 2'b00;
        repeat (2) tick;
        rst_fifo = 1'b0;
        tick;
        grant(1'b1, -1);
        req[1] = 1'b0;
        tick;
        chk("final_busy", int'(BUSY), 0);

        // Drain the scoreboard
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL %s: event never observed, required value %0d", kname(e.kind), e.value);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
